// File: rtl/linear_solver_pkg.sv
// Shared types, FSM encoding and the 3x3 determinant helper for the
// trilateration solver.
package linear_solver_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_BUILD   = 3'd2,
    S_DET     = 3'd3,
    S_SOLVE   = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  typedef real vec3_t [3];
  typedef real mat3_t [3][3];

  // Determinant of the matrix whose columns are c0, c1, c2 (cofactor row 0).
  function automatic real det3(input vec3_t c0, input vec3_t c1, input vec3_t c2);
    return c0[0] * (c1[1] * c2[2] - c2[1] * c1[2])
         - c1[0] * (c0[1] * c2[2] - c2[1] * c0[2])
         + c2[0] * (c0[1] * c1[2] - c1[1] * c0[2]);
  endfunction

endpackage

// File: rtl/linear_solver_if.sv
// Bundle of the solver's reference-point inputs and solution outputs.
interface linear_solver_if;
  real        x1, x2, x3, x4;
  real        y1, y2, y3, y4;
  real        z1, z2, z3, z4;
  real        r1, r2, r3, r4;
  real        c1, c2, c3;
  logic       done;
  logic [2:0] state;

  modport master (
    output x1, x2, x3, x4, y1, y2, y3, y4, z1, z2, z3, z4, r1, r2, r3, r4,
    input  c1, c2, c3, done, state
  );
  modport slave (
    input  x1, x2, x3, x4, y1, y2, y3, y4, z1, z2, z3, z4, r1, r2, r3, r4,
    output c1, c2, c3, done, state
  );
endinterface

// File: rtl/linear_solver.sv
// Free-running trilateration solver: sphere differencing into a 3x3 system,
// solved by Cramer's rule over a fixed CAPTURE..DONE sequence.
module linear_solver
  import linear_solver_pkg::*;
(
  input  logic       clk,
  input  real        x1, x2, x3, x4,
  input  real        y1, y2, y3, y4,
  input  real        z1, z2, z3, z4,
  input  real        r1, r2, r3, r4,
  output real        c1, c2, c3,
  output logic       done,
  output logic [2:0] state,
  input  logic       reset
);

  state_e state_q, state_d;
  logic   done_q;
  real    px_q [4];
  real    py_q [4];
  real    pz_q [4];
  real    pr_q [4];
  mat3_t  a_q;
  vec3_t  b_q;
  real    det_q [4];
  vec3_t  c_q;
  vec3_t  col0, col1, col2;

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:    state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_BUILD;
      S_BUILD:   state_d = S_DET;
      S_DET:     state_d = S_SOLVE;
      S_SOLVE:   state_d = S_DONE;
      S_DONE:    state_d = S_CAPTURE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      col0[r] = a_q[r][0];
      col1[r] = a_q[r][1];
      col2[r] = a_q[r][2];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        px_q[i]  <= 0.0;
        py_q[i]  <= 0.0;
        pz_q[i]  <= 0.0;
        pr_q[i]  <= 0.0;
        det_q[i] <= 0.0;
      end
      for (int k = 0; k < 3; k++) begin
        b_q[k] <= 0.0;
        c_q[k] <= 0.0;
        for (int j = 0; j < 3; j++) a_q[k][j] <= 0.0;
      end
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == S_DONE);
      case (state_q)
        S_CAPTURE: begin
          px_q[0] <= x1; px_q[1] <= x2; px_q[2] <= x3; px_q[3] <= x4;
          py_q[0] <= y1; py_q[1] <= y2; py_q[2] <= y3; py_q[3] <= y4;
          pz_q[0] <= z1; pz_q[1] <= z2; pz_q[2] <= z3; pz_q[3] <= z4;
          pr_q[0] <= r1; pr_q[1] <= r2; pr_q[2] <= r3; pr_q[3] <= r4;
        end
        // Row k is sphere k+1 minus sphere 0, linear in the unknowns.
        S_BUILD: begin
          for (int k = 0; k < 3; k++) begin
            a_q[k][0] <= 2.0 * (px_q[k+1] - px_q[0]);
            a_q[k][1] <= 2.0 * (py_q[k+1] - py_q[0]);
            a_q[k][2] <= 2.0 * (pz_q[k+1] - pz_q[0]);
            b_q[k]    <= pr_q[0] * pr_q[0] - pr_q[k+1] * pr_q[k+1]
                       + (px_q[k+1] * px_q[k+1] + py_q[k+1] * py_q[k+1] + pz_q[k+1] * pz_q[k+1])
                       - (px_q[0] * px_q[0] + py_q[0] * py_q[0] + pz_q[0] * pz_q[0]);
          end
        end
        S_DET: begin
          det_q[0] <= det3(col0, col1, col2);
          det_q[1] <= det3(b_q,  col1, col2);
          det_q[2] <= det3(col0, b_q,  col2);
          det_q[3] <= det3(col0, col1, b_q);
        end
        S_SOLVE: begin
          if (det_q[0] == 0.0) begin
            for (int k = 0; k < 3; k++) c_q[k] <= 0.0;
          end else begin
            for (int k = 0; k < 3; k++) c_q[k] <= det_q[k+1] / det_q[0];
          end
        end
        default: ;
      endcase
    end
  end

  assign c1    = c_q[0];
  assign c2    = c_q[1];
  assign c3    = c_q[2];
  assign done  = done_q;
  assign state = state_q;

endmodule

// File: tb/tb_linear_solver.sv
// Directed checks of the trilateration solver: exact, GPS-scale, singular,
// free-running capture isolation and mid-solve reset.
module tb_linear_solver;

  logic clk;
  logic reset;
  linear_solver_if bus ();

  linear_solver dut (
    .clk   (clk),
    .x1    (bus.x1), .x2 (bus.x2), .x3 (bus.x3), .x4 (bus.x4),
    .y1    (bus.y1), .y2 (bus.y2), .y3 (bus.y3), .y4 (bus.y4),
    .z1    (bus.z1), .z2 (bus.z2), .z3 (bus.z3), .z4 (bus.z4),
    .r1    (bus.r1), .r2 (bus.r2), .r3 (bus.r3), .r4 (bus.r4),
    .c1    (bus.c1), .c2 (bus.c2), .c3 (bus.c3),
    .done  (bus.done),
    .state (bus.state),
    .reset (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  checks   = 0;
  int  failures = 0;
  real px [4];
  real py [4];
  real pz [4];
  real pr [4];

  task automatic chk(input string tag, input real got, input real exp, input real tol);
    real diff;
    checks++;
    diff = got - exp;
    if (diff < 0.0) diff = -diff;
    if (!(diff <= tol)) begin
      failures++;
      $display("FAIL %s got=%g exp=%g", tag, got, exp);
    end
  endtask

  task automatic set_pt(input int i, input real x, input real y, input real z, input real r);
    px[i] = x; py[i] = y; pz[i] = z; pr[i] = r;
  endtask

  task automatic drive();
    bus.x1 = px[0]; bus.x2 = px[1]; bus.x3 = px[2]; bus.x4 = px[3];
    bus.y1 = py[0]; bus.y2 = py[1]; bus.y3 = py[2]; bus.y4 = py[3];
    bus.z1 = pz[0]; bus.z2 = pz[1]; bus.z3 = pz[2]; bus.z4 = pz[3];
    bus.r1 = pr[0]; bus.r2 = pr[1]; bus.r3 = pr[2]; bus.r4 = pr[3];
  endtask

  // Unit-axis centres shifted by dx along x; true solution is (1+dx, 2, 3).
  task automatic load_exact(input real dx);
    set_pt(0, dx + 0.0,  0.0,  0.0, 3.7416573868);
    set_pt(1, dx + 10.0, 0.0,  0.0, 9.6953597148);
    set_pt(2, dx + 0.0,  10.0, 0.0, 8.6023252670);
    set_pt(3, dx + 0.0,  0.0, 10.0, 7.3484692283);
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic walk(input string tag);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("%s_state%0d", tag, k), real'(bus.state), real'(k), 0.0);
      chk($sformatf("%s_done%0d", tag, k), real'(bus.done), (k == 5) ? 1.0 : 0.0, 0.0);
    end
  endtask

  task automatic chk_c(input string tag, input real e1, input real e2, input real e3, input real tol);
    chk({tag, "_c1"}, bus.c1, e1, tol);
    chk({tag, "_c2"}, bus.c2, e2, tol);
    chk({tag, "_c3"}, bus.c3, e3, tol);
  endtask

  initial begin
    reset = 1'b1;
    load_exact(0.0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", real'(bus.state), 0.0, 0.0);
    chk("rst_done", real'(bus.done), 0.0, 0.0);
    chk_c("rst", 0.0, 0.0, 0.0, 0.0);

    // Exact solve
    reset = 1'b0;
    walk("exact");
    chk_c("exact", 1.0, 2.0, 3.0, 1e-6);

    // GPS-scale: verify the difference equations hold on the returned point
    set_pt(0, 2088202.299,  -11757191.370, 25391471.881, 23204698.51);
    set_pt(1, 11092568.240, -14198201.090, 21471165.950, 21585835.37);
    set_pt(2, 35606984.591,  94447027.237,  9101378.572, 31364260.01);
    set_pt(3, 3966929.048,    7362851.831, 26388447.172, 24966798.73);
    drive();
    do_reset();
    walk("gps");
    for (int k = 1; k <= 3; k++) begin
      real t1, t2, t3, rhs, res, den;
      t1  = 2.0 * (px[k] - px[0]) * bus.c1;
      t2  = 2.0 * (py[k] - py[0]) * bus.c2;
      t3  = 2.0 * (pz[k] - pz[0]) * bus.c3;
      rhs = pr[0] * pr[0] - pr[k] * pr[k]
          + (px[k] * px[k] + py[k] * py[k] + pz[k] * pz[k])
          - (px[0] * px[0] + py[0] * py[0] + pz[0] * pz[0]);
      res = t1 + t2 + t3 - rhs;
      if (res < 0.0) res = -res;
      den = (t1 < 0.0 ? -t1 : t1) + (t2 < 0.0 ? -t2 : t2) + (t3 < 0.0 ? -t3 : t3)
          + (rhs < 0.0 ? -rhs : rhs);
      chk($sformatf("gps_resid%0d", k), res / den, 0.0, 1e-9);
    end

    // Singular: collinear centres
    set_pt(0, 0.0, 0.0, 0.0, 1.0);
    set_pt(1, 1.0, 0.0, 0.0, 2.0);
    set_pt(2, 2.0, 0.0, 0.0, 3.0);
    set_pt(3, 3.0, 0.0, 0.0, 4.0);
    drive();
    do_reset();
    walk("sing");
    chk_c("sing", 0.0, 0.0, 0.0, 0.0);

    // Free-running, inputs shifted during BUILD of the second solve
    load_exact(0.0);
    do_reset();
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("free_state%0d", k), real'(bus.state), real'(((k - 1) % 5) + 1), 0.0);
      chk($sformatf("free_done%0d", k), real'(bus.done), (k % 5 == 0) ? 1.0 : 0.0, 0.0);
      if (k == 7) load_exact(1.0);
      if (k == 5 || k == 8 || k == 10) chk_c($sformatf("free%0d", k), 1.0, 2.0, 3.0, 1e-6);
      if (k == 15) chk_c("free15", 2.0, 2.0, 3.0, 1e-6);
    end

    // Reset in DET after a completed solve
    load_exact(0.0);
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); @(negedge clk);
    end
    chk("mid_pre_state", real'(bus.state), 3.0, 0.0);
    chk_c("mid_pre", 1.0, 2.0, 3.0, 1e-6);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("mid_rst_state", real'(bus.state), 0.0, 0.0);
    chk("mid_rst_done", real'(bus.done), 0.0, 0.0);
    chk_c("mid_rst", 0.0, 0.0, 0.0, 0.0);
    reset = 1'b0;
    walk("mid_post");
    chk_c("mid_post", 1.0, 2.0, 3.0, 1e-6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
